msk_and_seq: RTL and testbench

MSK_AND_SEQ -- requirements
Module: msk_and_seq

---
 rtl/msk_and_seq.sv | 61 ++++++
 tb/tb_msk_and_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_and_seq.sv
// Sequencer around a masked AND gadget: skews a by one enabled cycle behind b/rnd, 2-cycle accept-to-result latency.
// A stalled result (out_valid & !out_ready) freezes the gadget and all state; nothing is accepted until it drains.
module msk_and_seq #(
  parameter int d = 2,
  localparam int N_RND = d * (d - 1) / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [d-1:0]     in_a,
  input  logic [d-1:0]     in_b,
  input  logic [N_RND-1:0] rnd_in,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  output logic [d-1:0]     g_ina,
  output logic [d-1:0]     g_inb,
  output logic [N_RND-1:0] g_rnd,
  output logic             g_en,
  input  logic [d-1:0]     g_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [d-1:0]     out_data,
  output logic             idle
);

  logic         s1_valid;
  logic         s2_valid;
  logic [d-1:0] a_skew;
  logic         out_ok;
  logic         take;

  // Randomness and operands are taken together so one rnd word maps to exactly one op.
  assign out_ok    = !s2_valid | out_ready;
  assign take      = !rst & in_valid & rnd_valid & out_ok;
  assign in_ready  = !rst & rnd_valid & out_ok;
  assign rnd_ready = take;
  assign g_en      = !rst & out_ok & (take | s1_valid | s2_valid);

  // Bubbles feed zero b shares so no stale operand shares reach the gadget.
  assign g_inb     = take ? in_b : '0;
  assign g_rnd     = rnd_in;
  assign g_ina     = a_skew;

  assign out_valid = s2_valid;
  assign out_data  = g_out;
  assign idle      = !s1_valid & !s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      a_skew   <= '0;
    end else if (g_en) begin
      s1_valid <= take;
      s2_valid <= s1_valid;
      a_skew   <= take ? in_a : '0;
    end
  end

endmodule

// File: tb/tb_msk_and_seq.sv
// Bench for msk_and_seq with a behavioural first-order masked AND gadget; scoreboard checks unmasked results.
module tb_msk_and_seq;
  localparam int D  = 2;
  localparam int NR = D * (D - 1) / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [D-1:0]  in_a;
  logic [D-1:0]  in_b;
  logic [NR-1:0] rnd_in;
  logic          rnd_valid;
  logic          rnd_ready;
  logic [D-1:0]  g_ina;
  logic [D-1:0]  g_inb;
  logic [NR-1:0] g_rnd;
  logic          g_en;
  logic [D-1:0]  g_out;
  logic          out_valid;
  logic          out_ready;
  logic [D-1:0]  out_data;
  logic          idle;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  msk_and_seq #(.d(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .g_ina(g_ina), .g_inb(g_inb), .g_rnd(g_rnd), .g_en(g_en),
    .g_out(g_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .idle(idle)
  );

  // Gadget model: b and rnd registered at edge 1, a joins in the next cycle, result registered at edge 2.
  logic [D-1:0]  gb_r = '0;
  logic [NR-1:0] gr_r = '0;
  logic [D-1:0]  go_r = '0;

  function automatic logic [D-1:0] gadget(input logic [D-1:0] a, input logic [D-1:0] b,
                                          input logic [NR-1:0] r);
    logic [D-1:0] c;
    int k;
    k = 0;
    for (int i = 0; i < D; i++) c[i] = a[i] & b[i];
    for (int i = 0; i < D; i++)
      for (int j = i + 1; j < D; j++) begin
        c[i] = c[i] ^ ((a[i] & b[j]) ^ r[k]);
        c[j] = c[j] ^ ((a[j] & b[i]) ^ r[k]);
        k++;
      end
    return c;
  endfunction

  always @(posedge clk) begin
    if (g_en === 1'b1) begin
      gb_r <= g_inb;
      gr_r <= g_rnd;
      go_r <= gadget(g_ina, gb_r, gr_r);
    end
  end
  assign g_out = go_r;

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_rnd = 0;
  bit exp_q[$];
  int acc_cyc_q[$];
  int lat_q[$];
  int out_cyc[$];
  logic          smp_rr;
  logic [D-1:0]  smp_ginb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every completed result handshake.
  always @(negedge clk) begin
    bit e;
    int ac;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e  = exp_q.pop_front();
        ac = acc_cyc_q.pop_front();
        lat_q.push_back(cyc - ac);
        chk("out_and", ^out_data, e);
      end
    end
    if (rnd_valid === 1'b1 && rnd_ready === 1'b1) n_rnd++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] split(input bit v);
    logic r;
    r = 1'($urandom);
    return {r ^ v, r};
  endfunction

  // Presents one operand pair for one cycle; records it in the scoreboard if taken.
  task automatic offer(input logic [1:0] a, input logic [1:0] b, input bit rv, output bit acc);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    rnd_valid = rv;
    rnd_in    = NR'($urandom);
    @(negedge clk);
    acc      = (in_ready === 1'b1);
    smp_rr   = rnd_ready;
    smp_ginb = g_inb;
    if (acc) begin
      exp_q.push_back((^a) & (^b));
      acc_cyc_q.push_back(cyc);
      n_acc++;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (idle !== 1'b1 && n < 50) begin
      step();
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, idle, 1);
    step();
  endtask

  task automatic chk_lat(input string name, input int exp);
    if (lat_q.size() == 0) chk(name, 32'hFFFF_FFFF, exp);
    else chk(name, lat_q.pop_front(), exp);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int r0;
    logic [D-1:0] dh;
    int tgt;
    int guard;

    rst = 1'b1; in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
    in_a = '0; in_b = '0; rnd_in = '0;
    step(); step();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rnd_ready", rnd_ready, 0);
    chk("rst_g_en", g_en, 0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_idle", idle, 1);
    step();

    // Single op a=1, b=1.
    offer(2'b10, 2'b01, 1'b1, acc);
    chk("t1_acc", acc, 1);
    @(negedge clk);
    chk("t1_lat1_valid", out_valid, 0);
    step();
    @(negedge clk);
    chk("t1_lat2_valid", out_valid, 1);
    chk("t1_xor", ^out_data, 1);
    step();
    @(negedge clk);
    chk("t1_idle", idle, 1);
    chk_lat("t1_latency", 2);
    step();

    // Three back-to-back ops.
    out_cyc.delete();
    r0 = n_rnd;
    offer(split(1), split(1), 1'b1, acc); chk("t2_acc0", acc, 1);
    offer(split(1), split(0), 1'b1, acc); chk("t2_acc1", acc, 1);
    offer(split(0), split(1), 1'b1, acc); chk("t2_acc2", acc, 1);
    wait_idle("t2");
    chk("t2_rnd_pulses", n_rnd - r0, 3);
    chk("t2_nout", out_cyc.size(), 3);
    if (out_cyc.size() == 3) chk("t2_consecutive", out_cyc[2] - out_cyc[0], 2);
    for (int i = 0; i < 3; i++) chk_lat("t2_latency", 2);

    // Output stall with a second op in s1.
    out_cyc.delete();
    offer(split(1), split(1), 1'b1, acc); chk("t3_accA", acc, 1);
    offer(split(1), split(0), 1'b1, acc); chk("t3_accB", acc, 1);
    out_ready = 1'b0;
    in_a = split(1); in_b = split(1); in_valid = 1'b1; rnd_valid = 1'b1;
    @(negedge clk);
    dh = out_data;
    chk("t3_stall_valid", out_valid, 1);
    chk("t3_stall_g_en", g_en, 0);
    chk("t3_stall_in_ready", in_ready, 0);
    chk("t3_stall_rnd_ready", rnd_ready, 0);
    chk("t3_a_value", ^out_data, 1);
    for (int i = 1; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("t3_hold_data", out_data, dh);
      chk("t3_hold_g_en", g_en, 0);
      chk("t3_hold_in_ready", in_ready, 0);
      chk("t3_hold_valid", out_valid, 1);
    end
    step();
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("t3_rel_valid0", out_valid, 1);
    step();
    @(negedge clk);
    chk("t3_rel_valid1", out_valid, 1);
    chk("t3_b_value", ^out_data, 0);
    step();
    @(negedge clk);
    chk("t3_rel_empty", out_valid, 0);
    step();
    chk("t3_nout", out_cyc.size(), 2);
    if (out_cyc.size() == 2) chk("t3_consecutive", out_cyc[1] - out_cyc[0], 1);
    chk_lat("t3_latA", 6);
    chk_lat("t3_latB", 6);

    // Randomness starvation while a prior op drains.
    r0 = n_rnd;
    offer(split(1), split(1), 1'b1, acc); chk("t4_acc", acc, 1);
    for (int i = 0; i < 3; i++) begin
      offer(split(1), split(1), 1'b0, acc);
      chk("t4_no_acc", acc, 0);
      chk("t4_rnd_ready", smp_rr, 0);
      chk("t4_ginb_zero", smp_ginb, 0);
    end
    rnd_valid = 1'b1;
    wait_idle("t4");
    chk_lat("t4_latency", 2);
    chk("t4_rnd_used", n_rnd - r0, 1);

    // Reset one cycle after accepting an op.
    offer(split(1), split(1), 1'b1, acc); chk("t5_acc", acc, 1);
    rst = 1'b1; in_valid = 1'b1; rnd_valid = 1'b1;
    @(negedge clk);
    chk("t5_rst_in_ready", in_ready, 0);
    chk("t5_rst_g_en", g_en, 0);
    chk("t5_rst_rnd_ready", rnd_ready, 0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete(); acc_cyc_q.delete(); lat_q.delete(); out_cyc.delete();
    @(negedge clk);
    chk("t5_idle", idle, 1);
    chk("t5_no_valid0", out_valid, 0);
    step();
    @(negedge clk);
    chk("t5_no_valid1", out_valid, 0);
    step();
    offer(split(0), split(1), 1'b1, acc); chk("t5_next_acc", acc, 1);
    wait_idle("t5");
    chk("t5_nout", out_cyc.size(), 1);
    chk_lat("t5_latency", 2);

    // Random stalls on all three handshakes.
    tgt = n_acc + 10000;
    guard = 0;
    while (n_acc < tgt && guard < 80000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      rnd_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = D'($urandom);
      in_b      = D'($urandom);
      rnd_in    = NR'($urandom);
      @(negedge clk);
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back((^in_a) & (^in_b));
        acc_cyc_q.push_back(cyc);
        n_acc++;
      end
      step();
      guard++;
    end
    chk("t6_all_accepted", (n_acc >= tgt), 1);
    in_valid = 1'b0; rnd_valid = 1'b1; out_ready = 1'b1;
    wait_idle("t6");
    chk("t6_scoreboard_empty", exp_q.size(), 0);
    chk("rnd_vs_ops", n_rnd, n_acc);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
